rop_addr_gen: RTL and testbench

Fragment-to-memory address generator for the ROP unit. Accepts one fragment per handshake (position, tag) from the ROP CSR front end. Combines it with the ROP DCR state (color/depth buffer base and pitch, test enables) and serializes the required depth-stencil and color read requests onto a single memory-request port. The request port feeds the ROP memory interface; the tag lets the downstream depth/blend stages rejoin data with fragment state.

---
 rtl/rop_addr_gen.sv | 232 +++++++++++++++++++++++
 tb/tb_rop_addr_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rop_addr_gen.sv
// rop_addr_gen: fragment-to-memory address generator for the ROP unit.
// Takes one fragment per handshake, registers it together with the DCR state
// in stage 1, then serializes the depth-stencil and/or color read beats (or a
// single null beat) onto one memory-request port.
// Optional feature macro: ROP_STENCIL_EN. When it is defined, the stencil
// enables contribute to need_z. When it is undefined, only depth_enable does.
module rop_addr_gen #(
    parameter int DIM_BITS   = 12,
    parameter int PITCH_BITS = 13,
    parameter int ADDR_BITS  = 25,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  frag_valid,
    output logic                  frag_ready,
    input  logic [DIM_BITS-1:0]   frag_pos_x,
    input  logic [DIM_BITS-1:0]   frag_pos_y,
    input  logic [TAG_WIDTH-1:0]  frag_tag,

    input  logic [ADDR_BITS-1:0]  cbuf_addr,
    input  logic [ADDR_BITS-1:0]  zbuf_addr,
    input  logic [PITCH_BITS-1:0] cbuf_pitch,
    input  logic [PITCH_BITS-1:0] zbuf_pitch,
    input  logic                  depth_enable,
    input  logic [1:0]            stencil_enable,
    input  logic                  blend_enable,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_BITS-1:0]  mem_req_addr,
    output logic                  mem_req_sel,
    output logic                  mem_req_rd,
    output logic                  mem_req_last,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,

    output logic                  busy
);

    localparam int PROD_BITS = DIM_BITS + PITCH_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ZREQ,
        ST_CREQ,
        ST_NULLREQ
    } state_t;

    // ------------------------------------------------------------------
    // DCR-derived request needs and row-offset products (input side)
    // ------------------------------------------------------------------
    logic                 w_need_z;
    logic                 w_need_c;
    logic [PROD_BITS-1:0] w_zprod;
    logic [PROD_BITS-1:0] w_cprod;

    // Decide which buffers this fragment must read.
    always_comb begin
`ifdef ROP_STENCIL_EN
        w_need_z = depth_enable | (|stencil_enable);
`else
        // The stencil port remains for compatibility; its contribution is masked off.
        w_need_z = depth_enable | ((|stencil_enable) & 1'b0);
`endif
        w_need_c = blend_enable;
    end

    // The full-width y*pitch products are formed before truncation to the address width.
    assign w_zprod = PROD_BITS'(frag_pos_y) * PROD_BITS'(zbuf_pitch);
    assign w_cprod = PROD_BITS'(frag_pos_y) * PROD_BITS'(cbuf_pitch);

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic                 r_s1_valid;
    logic [DIM_BITS-1:0]  r_s1_pos_x;
    logic [TAG_WIDTH-1:0] r_s1_tag;
    logic                 r_s1_need_z;
    logic                 r_s1_need_c;
    logic [ADDR_BITS-1:0] r_s1_zbase;
    logic [ADDR_BITS-1:0] r_s1_cbase;
    logic [PROD_BITS-1:0] r_s1_zprod;
    logic [PROD_BITS-1:0] r_s1_cprod;

    logic                 w_s1_capture;
    logic                 w_load;
    logic [ADDR_BITS-1:0] w_s1_zaddr;
    logic [ADDR_BITS-1:0] w_s1_caddr;

    assign w_s1_capture = frag_valid & frag_ready;

    // Capture an accepted fragment and sample the DCRs. Clear stage 1 when the issue FSM takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_pos_x  <= '0;
            r_s1_tag    <= '0;
            r_s1_need_z <= 1'b0;
            r_s1_need_c <= 1'b0;
            r_s1_zbase  <= '0;
            r_s1_cbase  <= '0;
            r_s1_zprod  <= '0;
            r_s1_cprod  <= '0;
        end else if (w_s1_capture) begin
            r_s1_valid  <= 1'b1;
            r_s1_pos_x  <= frag_pos_x;
            r_s1_tag    <= frag_tag;
            r_s1_need_z <= w_need_z;
            r_s1_need_c <= w_need_c;
            r_s1_zbase  <= zbuf_addr;
            r_s1_cbase  <= cbuf_addr;
            r_s1_zprod  <= w_zprod;
            r_s1_cprod  <= w_cprod;
        end else if (w_load) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // Final byte addresses. These are 4 bytes per pixel and wrap modulo 2^ADDR_BITS.
    assign w_s1_zaddr = ADDR_BITS'(r_s1_zbase) + ADDR_BITS'(r_s1_zprod)
                      + ADDR_BITS'({r_s1_pos_x, 2'b00});
    assign w_s1_caddr = ADDR_BITS'(r_s1_cbase) + ADDR_BITS'(r_s1_cprod)
                      + ADDR_BITS'({r_s1_pos_x, 2'b00});

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_BITS-1:0] r_zaddr;
    logic [ADDR_BITS-1:0] r_caddr;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_need_c;
    logic                 w_done;

    // Issue state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the addresses and tag of the fragment that the FSM is loading from stage 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zaddr  <= '0;
            r_caddr  <= '0;
            r_tag    <= '0;
            r_need_c <= 1'b0;
        end else if (w_load) begin
            r_zaddr  <= w_s1_zaddr;
            r_caddr  <= w_s1_caddr;
            r_tag    <= r_s1_tag;
            r_need_c <= r_s1_need_c;
        end
    end

    // Compute the beat outputs for the current state, the next state, and the load/accept decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_done        = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_sel   = 1'b0;
        mem_req_rd    = 1'b0;
        mem_req_last  = 1'b0;
        mem_req_tag   = '0;

        case (r_state)
            ST_ZREQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_zaddr;
                mem_req_rd    = 1'b1;
                mem_req_last  = ~r_need_c;
                mem_req_tag   = r_tag;
                if (mem_req_ready) begin
                    if (r_need_c) begin
                        w_state_nxt = ST_CREQ;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            ST_CREQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_caddr;
                mem_req_sel   = 1'b1;
                mem_req_rd    = 1'b1;
                mem_req_last  = 1'b1;
                mem_req_tag   = r_tag;
                if (mem_req_ready) begin
                    w_done = 1'b1;
                end
            end
            ST_NULLREQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_zaddr;
                mem_req_last  = 1'b1;
                mem_req_tag   = r_tag;
                if (mem_req_ready) begin
                    w_done = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Loading on a last-beat handshake keeps back-to-back fragments bubble-free.
        w_load = r_s1_valid & ((r_state == ST_IDLE) | w_done);

        if (w_load) begin
            if (r_s1_need_z) begin
                w_state_nxt = ST_ZREQ;
            end else if (r_s1_need_c) begin
                w_state_nxt = ST_CREQ;
            end else begin
                w_state_nxt = ST_NULLREQ;
            end
        end else if (w_done) begin
            w_state_nxt = ST_IDLE;
        end

        frag_ready = ~r_s1_valid | w_load;
    end

    // A fragment is in flight while it is held in stage 1 or in the issue stage.
    assign busy = r_s1_valid | (r_state != ST_IDLE);

endmodule

// File: tb/tb_rop_addr_gen.sv
// tb_rop_addr_gen: self-checking bench for rop_addr_gen.
// The bench model turns every accepted fragment into its expected list of beats.
// The model uses plain address arithmetic and the request-enable rules.
// A negedge monitor pops one expected beat per handshake and compares it with the DUT output.
// The same monitor checks that the request is held stable during backpressure.
// Directed sections pin the model with hand-computed literals.
module tb_rop_addr_gen;

    localparam int DIM_BITS   = 12;
    localparam int PITCH_BITS = 13;
    localparam int ADDR_BITS  = 25;
    localparam int TAG_WIDTH  = 8;

`ifdef ROP_STENCIL_EN
    localparam logic STEN_RD = 1'b1;
`else
    localparam logic STEN_RD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic                  frag_valid;
    logic                  frag_ready;
    logic [DIM_BITS-1:0]   frag_pos_x;
    logic [DIM_BITS-1:0]   frag_pos_y;
    logic [TAG_WIDTH-1:0]  frag_tag;
    logic [ADDR_BITS-1:0]  cbuf_addr;
    logic [ADDR_BITS-1:0]  zbuf_addr;
    logic [PITCH_BITS-1:0] cbuf_pitch;
    logic [PITCH_BITS-1:0] zbuf_pitch;
    logic                  depth_enable;
    logic [1:0]            stencil_enable;
    logic                  blend_enable;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_BITS-1:0]  mem_req_addr;
    logic                  mem_req_sel;
    logic                  mem_req_rd;
    logic                  mem_req_last;
    logic [TAG_WIDTH-1:0]  mem_req_tag;
    logic                  busy;

    rop_addr_gen #(
        .DIM_BITS  (DIM_BITS),
        .PITCH_BITS(PITCH_BITS),
        .ADDR_BITS (ADDR_BITS),
        .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frag_valid    (frag_valid),
        .frag_ready    (frag_ready),
        .frag_pos_x    (frag_pos_x),
        .frag_pos_y    (frag_pos_y),
        .frag_tag      (frag_tag),
        .cbuf_addr     (cbuf_addr),
        .zbuf_addr     (zbuf_addr),
        .cbuf_pitch    (cbuf_pitch),
        .zbuf_pitch    (zbuf_pitch),
        .depth_enable  (depth_enable),
        .stencil_enable(stencil_enable),
        .blend_enable  (blend_enable),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_sel   (mem_req_sel),
        .mem_req_rd    (mem_req_rd),
        .mem_req_last  (mem_req_last),
        .mem_req_tag   (mem_req_tag),
        .busy          (busy)
    );

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic                 sel;
        logic                 rd;
        logic                 last;
        logic [TAG_WIDTH-1:0] tag;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    obs_cyc[$];
    beat_t held;
    logic  prev_stall = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Byte address of pixel (x,y) in a 4-byte-per-pixel buffer, wrapped to the address width.
    function automatic logic [ADDR_BITS-1:0] pix_addr(input longint base, input longint pitch,
                                                      input longint x, input longint y);
        longint a;
        a = (base + y * pitch + x * 4) % (longint'(1) << ADDR_BITS);
        return ADDR_BITS'(a);
    endfunction

    // Expected beats for the fragment that is accepted at the coming edge.
    task automatic model_accept();
        logic  nz;
        logic  nc;
        beat_t b;
`ifdef ROP_STENCIL_EN
        nz = depth_enable | (stencil_enable != 2'b00);
`else
        nz = depth_enable;
`endif
        nc = blend_enable;
        b.tag = frag_tag;
        if (nz) begin
            b.addr = pix_addr(longint'(zbuf_addr), longint'(zbuf_pitch),
                              longint'(frag_pos_x), longint'(frag_pos_y));
            b.sel = 1'b0; b.rd = 1'b1; b.last = ~nc;
            exp_q.push_back(b);
        end
        if (nc) begin
            b.addr = pix_addr(longint'(cbuf_addr), longint'(cbuf_pitch),
                              longint'(frag_pos_x), longint'(frag_pos_y));
            b.sel = 1'b1; b.rd = 1'b1; b.last = 1'b1;
            exp_q.push_back(b);
        end
        if (!nz && !nc) begin
            b.addr = pix_addr(longint'(zbuf_addr), longint'(zbuf_pitch),
                              longint'(frag_pos_x), longint'(frag_pos_y));
            b.sel = 1'b0; b.rd = 1'b0; b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    // Compare process: sample between edges, then check the handshakes that the next edge will perform.
    always @(negedge clk) begin
        beat_t cur;
        cur.addr = mem_req_addr;
        cur.sel  = mem_req_sel;
        cur.rd   = mem_req_rd;
        cur.last = mem_req_last;
        cur.tag  = mem_req_tag;
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", {mem_req_valid, cur}, {1'b1, held});
            if (frag_valid && frag_ready)
                model_accept();
            if (mem_req_valid && mem_req_ready) begin
                obs_q.push_back(cur);
                obs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {1'b1, cur}, 0);
                end else begin
                    chk("beat", cur, exp_q.pop_front());
                end
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            held = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        frag_valid    = 1'b0;
        mem_req_ready = 1'b1;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_frag_ready"}, frag_ready, 1);
        chk({name, "_valid"}, mem_req_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_beat"}, {mem_req_addr, mem_req_sel, mem_req_rd, mem_req_last, mem_req_tag}, 0);
    endtask

    task automatic send(input int x, input int y, input int tag);
        frag_pos_x = DIM_BITS'(x);
        frag_pos_y = DIM_BITS'(y);
        frag_tag   = TAG_WIDTH'(tag);
        frag_valid = 1'b1;
        tick();
        frag_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        frag_valid     = 1'b1;
        frag_pos_x     = '0;
        frag_pos_y     = '0;
        frag_tag       = 8'h77;
        cbuf_addr      = '0;
        zbuf_addr      = '0;
        cbuf_pitch     = '0;
        zbuf_pitch     = '0;
        depth_enable   = 1'b1;
        stencil_enable = 2'b00;
        blend_enable   = 1'b1;
        mem_req_ready  = 1'b1;

        // Reset held with frag_valid high: nothing may be captured.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_frag_ready", frag_ready, 1);
            chk("rst_valid", mem_req_valid, 0);
        end
        reset      = 1'b0;
        frag_valid = 1'b0;
        #1;
        check_idle_outputs("post_reset");
        tick();
        chk("post_reset_busy2", busy, 0);

        // Address math and first-beat latency.
        zbuf_addr = 25'h1000; zbuf_pitch = 13'h400;
        cbuf_addr = 25'h80000; cbuf_pitch = 13'h800;
        depth_enable = 1'b1; blend_enable = 1'b1; stencil_enable = 2'b00;
        obs_q.delete(); obs_cyc.delete();
        frag_pos_x = 12'd3; frag_pos_y = 12'd2; frag_tag = 8'h5A; frag_valid = 1'b1;
        chk("am_frag_ready", frag_ready, 1);
        tick();
        frag_valid = 1'b0;
        chk("am_lat_n1_valid", mem_req_valid, 0);
        tick();
        chk("am_lat_n2_valid", mem_req_valid, 1);
        chk("am_beat1", {mem_req_addr, mem_req_sel, mem_req_rd, mem_req_last, mem_req_tag},
            {25'h180C, 1'b0, 1'b1, 1'b0, 8'h5A});
        tick();
        chk("am_beat2", {mem_req_valid, mem_req_addr, mem_req_sel, mem_req_rd, mem_req_last, mem_req_tag},
            {1'b1, 25'h8100C, 1'b1, 1'b1, 1'b1, 8'h5A});
        tick();
        chk("am_after_valid", mem_req_valid, 0);
        drain("am_drain");

        // Null path: four fragments streamed back-to-back at one beat per cycle.
        depth_enable = 1'b0; blend_enable = 1'b0; stencil_enable = 2'b00;
        obs_q.delete(); obs_cyc.delete();
        for (int i = 1; i <= 4; i++) begin
            frag_pos_x = DIM_BITS'(i); frag_pos_y = '0;
            frag_tag = TAG_WIDTH'(i); frag_valid = 1'b1;
            chk("null_frag_ready", frag_ready, 1);
            tick();
        end
        drain("null_drain");
        chk("null_count", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("null_rd_last_tag", {obs_q[i].rd, obs_q[i].last, obs_q[i].tag},
                    {1'b0, 1'b1, 8'(i + 1)});
                chk("null_spacing", obs_cyc[i] - obs_cyc[0], i);
            end
        end

        // Backpressure: hold the first Z beat for 5 cycles while stage 1 is full.
        depth_enable = 1'b1; blend_enable = 1'b1;
        mem_req_ready = 1'b0;
        obs_q.delete(); obs_cyc.delete();
        frag_pos_x = 12'd5; frag_pos_y = 12'd1; frag_tag = 8'hA1; frag_valid = 1'b1;
        tick();
        frag_pos_x = 12'd6; frag_tag = 8'hA2;
        tick();
        frag_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_frag_ready", frag_ready, 0);
            chk("bp_beat", {mem_req_valid, mem_req_addr, mem_req_sel, mem_req_tag},
                {1'b1, 25'h1414, 1'b0, 8'hA1});
            tick();
        end
        drain("bp_drain");
        chk("bp_count", obs_q.size(), 4);

        // Wrap-around of the byte address.
        zbuf_addr = 25'h1FFFFFC; zbuf_pitch = 13'h100;
        depth_enable = 1'b1; blend_enable = 1'b0;
        obs_q.delete(); obs_cyc.delete();
        send(1, 0, 8'h33);
        drain("wrap_drain");
        chk("wrap_count", obs_q.size(), 1);
        if (obs_q.size() == 1)
            chk("wrap_addr", {obs_q[0].addr, obs_q[0].rd}, {25'h0, 1'b1});

        // Stencil-only fragment: a real depth read only when the stencil option is built in.
        zbuf_addr = 25'h2000; zbuf_pitch = 13'h40;
        depth_enable = 1'b0; blend_enable = 1'b0; stencil_enable = 2'b01;
        obs_q.delete(); obs_cyc.delete();
        send(2, 1, 8'h44);
        drain("cfg_drain");
        chk("cfg_count", obs_q.size(), 1);
        if (obs_q.size() == 1)
            chk("cfg_beat", {obs_q[0].addr, obs_q[0].sel, obs_q[0].rd, obs_q[0].last},
                {25'h2048, 1'b0, STEN_RD, 1'b1});

        // Randomized phases. The DCRs change only while the block is idle.
        for (int ph = 0; ph < 8; ph++) begin
            drain("rnd_idle");
            zbuf_addr      = ADDR_BITS'($urandom);
            cbuf_addr      = ADDR_BITS'($urandom);
            zbuf_pitch     = PITCH_BITS'($urandom);
            cbuf_pitch     = PITCH_BITS'($urandom);
            depth_enable   = 1'($urandom_range(0, 1));
            blend_enable   = 1'($urandom_range(0, 1));
            stencil_enable = 2'($urandom_range(0, 3));
            for (int c = 0; c < 80; c++) begin
                frag_valid    = ($urandom_range(0, 3) != 0);
                frag_pos_x    = DIM_BITS'($urandom);
                frag_pos_y    = DIM_BITS'($urandom);
                frag_tag      = TAG_WIDTH'($urandom);
                mem_req_ready = (ph[0] == 1'b1) ? 1'b1 : ($urandom_range(0, 2) != 0);
                if (ph == 5 && c == 40) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    frag_valid = 1'b0;
                    #1;
                    check_idle_outputs("mid_reset");
                end else begin
                    tick();
                end
            end
        end
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
